// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path (frame controller and parity helpers).
//   tx_state_e : frame sequencer states
//   PAR_*      : parity type encodings as carried on PAR_TYP
//   *_BIT/LVL  : serial line levels
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Bundle of the frame controller's host-side and serializer-side signals.
//   master : upstream/serializer side (drives request, data, parity settings, SER_Data/SER_Done)
//   slave  : uart_tx_ctrl (drives SER_EN, SER_P_Data, TX_OUT, Busy, Frame_Err)
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  SER_Data;
  logic                  SER_Done;
  logic                  SER_EN;
  logic [DATA_WIDTH-1:0] SER_P_Data;
  logic                  TX_OUT;
  logic                  Busy;
  logic                  Frame_Err;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, SER_Data, SER_Done,
    input  SER_EN, SER_P_Data, TX_OUT, Busy, Frame_Err
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, SER_Data, SER_Done,
    output SER_EN, SER_P_Data, TX_OUT, Busy, Frame_Err
  );

endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity generator, shared between the TX controller and the RX checker.
//   data       : word to cover
//   par_typ    : PAR_EVEN / PAR_ODD
//   parity_bit : bit that makes the total count of ones even/odd
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity_bit
);

  assign parity_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, DATA_WIDTH serializer bits, optional parity, stop.
// One bit per CLK; baud pacing is done upstream.
//   CLK, RST : clock (rising edge), asynchronous active-low reset
//   bus      : uart_tx_ctrl_if.slave carrying P_DATA/Data_Valid/PAR_EN/PAR_TYP in,
//              SER_Data/SER_Done in, SER_EN/SER_P_Data/TX_OUT/Busy/Frame_Err out
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WDOG_MARGIN = 2
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_ctrl_if.slave  bus
);

  localparam int unsigned WdogLimit = DATA_WIDTH + WDOG_MARGIN;
  localparam int unsigned CntW      = $clog2(WdogLimit + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(WdogLimit);
  // Last DATA cycle allowed: the counter reaches WdogLimit on the edge leaving it.
  localparam logic [CntW-1:0] CntLast = CntW'(WdogLimit - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  frame_err_q, frame_err_d;

  logic                  accept;
  logic                  parity_bit;
  logic                  tx_out;
  logic                  ser_en;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data      (data_q),
    .par_typ   (par_typ_q),
    .parity_bit(parity_bit)
  );

  // Requests are only taken when the line is idle or on the stop bit (back-to-back frames).
  assign accept = bus.Data_Valid && ((state_q == IDLE) || (state_q == STOP));

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    cnt_d       = cnt_q;
    frame_err_d = frame_err_q;
    tx_out      = IDLE_LVL;
    ser_en      = 1'b0;

    if (accept) begin
      data_d      = bus.P_DATA;
      par_en_d    = bus.PAR_EN;
      par_typ_d   = bus.PAR_TYP;
      frame_err_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        tx_out = IDLE_LVL;
        if (accept) state_d = START;
      end
      START: begin
        tx_out  = START_BIT;
        ser_en  = 1'b1;
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        tx_out = bus.SER_Data;
        ser_en = 1'b1;
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        if (bus.SER_Done) begin
          state_d = par_en_q ? PARITY : STOP;
        end else if (cnt_q >= CntLast) begin
          // Serializer never reported done: close the frame without parity.
          frame_err_d = 1'b1;
          state_d     = STOP;
        end
      end
      PARITY: begin
        tx_out  = parity_bit;
        state_d = STOP;
      end
      STOP: begin
        tx_out  = STOP_BIT;
        state_d = accept ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      data_q      <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      par_en_q    <= par_en_d;
      par_typ_q   <= par_typ_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.TX_OUT     = tx_out;
  assign bus.SER_EN     = ser_en;
  assign bus.SER_P_Data = data_q;
  assign bus.Busy       = (state_q != IDLE);
  assign bus.Frame_Err  = frame_err_q;

endmodule
